// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing a single unsigned magnitude comparator
// between N_REQ requesters. Each compare takes three cycles: one to grant
// and latch the operands, one to compare, and one to pulse done.

// Combinational unsigned relational comparator, the shared datapath.
module comparator_rel #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             eq_o,
  output logic             gt_o,
  output logic             lt_o
);

  // Exactly one of the three relations is true for any operand pair.
  always_comb begin
    eq_o = (a_i == b_i);
    gt_o = (a_i >  b_i);
    lt_o = (a_i <  b_i);
  end

endmodule

module cmp_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   a_in,
  input  logic [N_REQ*WIDTH-1:0]   b_in,
  output logic [N_REQ-1:0]         done,
  output logic                     eq,
  output logic                     gt,
  output logic                     lt,
  output logic                     busy
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     cur_q,   cur_d;
  logic [IDX_W-1:0]     ptr_q,   ptr_d;
  logic [WIDTH-1:0]     op_a_q,  op_a_d;
  logic [WIDTH-1:0]     op_b_q,  op_b_d;
  logic                 eq_q,    eq_d;
  logic                 gt_q,    gt_d;
  logic                 lt_q,    lt_d;
  logic [N_REQ-1:0]     done_q,  done_d;
  logic                 busy_q,  busy_d;

  logic                 grant_vld_c;
  logic [IDX_W-1:0]     grant_idx_c;
  logic [WIDTH-1:0]     a_sel_c;
  logic [WIDTH-1:0]     b_sel_c;
  int unsigned          cand_c;

  logic                 cmp_eq_c;
  logic                 cmp_gt_c;
  logic                 cmp_lt_c;

  // Shared comparator sees only the latched operands, never the live inputs.
  comparator_rel #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .a_i  (op_a_q),
    .b_i  (op_b_q),
    .eq_o (cmp_eq_c),
    .gt_o (cmp_gt_c),
    .lt_o (cmp_lt_c)
  );

  // Round-robin search starting just after the last served requester.
  always_comb begin
    grant_vld_c = 1'b0;
    grant_idx_c = '0;
    cand_c      = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand_c = (32'(ptr_q) + k) % N_REQ;
      if (!grant_vld_c && req[IDX_W'(cand_c)]) begin
        grant_vld_c = 1'b1;
        grant_idx_c = IDX_W'(cand_c);
      end
    end
  end

  // Operand slice mux for the winning requester.
  always_comb begin
    a_sel_c = '0;
    b_sel_c = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (grant_idx_c == IDX_W'(k)) begin
        a_sel_c = a_in[k*WIDTH +: WIDTH];
        b_sel_c = b_in[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and next-output logic; every register holds unless updated.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    ptr_d   = ptr_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    done_d  = '0;
    busy_d  = busy_q;

    unique case (state_q)
      IDLE: begin
        if (grant_vld_c) begin
          op_a_d  = a_sel_c;
          op_b_d  = b_sel_c;
          cur_d   = grant_idx_c;
          busy_d  = 1'b1;
          state_d = CMP;
        end
      end
      CMP: begin
        eq_d    = cmp_eq_c;
        gt_d    = cmp_gt_c;
        lt_d    = cmp_lt_c;
        done_d  = N_REQ'(1) << cur_q;
        state_d = DONE;
      end
      DONE: begin
        ptr_d   = cur_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      ptr_q   <= IDX_W'(N_REQ - 1);
      op_a_q  <= '0;
      op_b_q  <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      ptr_q   <= ptr_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign done = done_q;
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign lt   = lt_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and compares whenever done pulses.
module tb_cmp_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned WIDTH = 8;

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] a_in;
  logic [N_REQ*WIDTH-1:0] b_in;
  logic [N_REQ-1:0]       done;
  logic                   eq, gt, lt, busy;

  typedef struct {
    int       idx;
    logic [2:0] res;   // {eq, gt, lt}
    int       cyc;     // cycle count at which done must be visible
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   n_checks;
  int   n_pass;

  localparam logic [2:0] R_EQ = 3'b100;
  localparam logic [2:0] R_GT = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;

  cmp_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .a_in (a_in),
    .b_in (b_in),
    .done (done),
    .eq   (eq),
    .gt   (gt),
    .lt   (lt),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    a_in[i*WIDTH +: WIDTH] = a;
    b_in[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic expect_done(input int idx, input logic [2:0] res, input int at_cyc);
    exp_t e;
    e.idx = idx;
    e.res = res;
    e.cyc = at_cyc;
    q.push_back(e);
  endtask

  // One compare on a single requester: req up for the grant cycle only.
  task automatic single(input int idx, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [2:0] res);
    set_ops(idx, a, b);
    req = '0;
    req[idx] = 1'b1;
    expect_done(idx, res, cyc + 2);
    step(1);
    req = '0;
    step(2);
  endtask

  // Monitor: compare every done pulse against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk("missed_done", 32'(e.idx), 32'hFFFF_FFFF);
      end
      if (done != '0) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'h0);
        end else begin
          e = q.pop_front();
          chk("done_onehot", 32'(done), 32'(1) << e.idx);
          chk("result", 32'({eq, gt, lt}), 32'(e.res));
          chk("latency", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    cyc = 0; n_checks = 0; n_pass = 0;
    rst = 1'b1; req = '0; a_in = '0; b_in = '0;
    #1;
    chk("reset_outs", 32'({done, eq, gt, lt, busy}), 32'h0);
    step(2);
    rst = 1'b0;
    step(1);

    // Scenario 1: single requester, equal operands; busy profile checked.
    set_ops(0, 8'd50, 8'd50);
    req = 4'b0001;
    expect_done(0, R_EQ, cyc + 2);
    chk("s1_busy_idle", 32'(busy), 32'd0);
    step(1);
    req = '0;
    chk("s1_busy_cmp", 32'(busy), 32'd1);
    chk("s1_done_cmp", 32'(done), 32'd0);
    step(1);
    chk("s1_busy_done", 32'(busy), 32'd1);
    step(1);
    chk("s1_busy_back", 32'(busy), 32'd0);
    chk("s1_done_idle", 32'(done), 32'd0);

    // Scenario 2: unsigned gt / lt / eq on requester 2.
    single(2, 8'd200, 8'd199, R_GT);
    single(2, 8'd0,   8'd10,  R_LT);
    single(2, 8'd255, 8'd255, R_EQ);

    // Scenario 3: all requesters held; reset first so index 0 leads.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    for (int i = 0; i < 4; i++) set_ops(i, 8'd100, 8'd50);
    req = 4'b1111;
    for (int k = 0; k < 6; k++) expect_done(k % 4, R_GT, cyc + 2 + 3 * k);
    step(17);
    req = '0;
    step(3);

    // Scenario 4: operand change and req drop after grant are ignored.
    set_ops(1, 8'd25, 8'd50);
    req = 4'b0010;
    expect_done(1, R_LT, cyc + 2);
    step(1);
    set_ops(1, 8'd99, 8'd50);
    req = '0;
    step(2);
    step(3);
    chk("s4_hold_lt", 32'({eq, gt, lt}), 32'(R_LT));

    // Scenario 5: reset during CMP clears outputs without a clock edge.
    set_ops(0, 8'd7, 8'd7);
    req = 4'b0001;
    step(1);
    req = '0;
    chk("s5_busy_before", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("s5_async_outs", 32'({done, eq, gt, lt, busy}), 32'h0);
    step(2);
    chk("s5_held_outs", 32'({done, eq, gt, lt, busy}), 32'h0);

    // Scenario 6: requests raised with reset release; index 1 then 3.
    set_ops(1, 8'd10, 8'd20);
    set_ops(3, 8'd30, 8'd30);
    rst = 1'b0;
    req = 4'b1010;
    expect_done(1, R_LT, cyc + 2);
    expect_done(3, R_EQ, cyc + 5);
    step(5);
    req = '0;
    step(6);

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    chk("idle_at_end", 32'({done, busy}), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
